// File: rtl/prold_loader.sv
// Program loader: turns a big-endian UART byte stream (length word, then
// instructions) into prold_info write orders, then acks on TX and releases the core.
module prold_loader #(
   parameter int unsigned         LEN_WORD       = 32,
   parameter int unsigned         LEN_PROLD_INFO = 2 + 2*LEN_WORD,
   parameter logic [LEN_WORD-1:0] START_PC       = '0,
   parameter int unsigned         DRAIN_CYCLES   = 4,
   parameter logic [7:0]          ACK_BYTE       = 8'hAA
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      rx_valid,
   input  logic [7:0]                rx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [7:0]                tx_data,
   output logic [LEN_PROLD_INFO-1:0] prold_info,
   output logic                      load_done
);

   localparam int unsigned DRAIN_W = 4;

   typedef enum logic [2:0] {S_LEN, S_DATA, S_DRAIN, S_ACK, S_RUN} state_t;

   state_t               state_q, state_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [LEN_WORD-1:0]  shift_q, shift_d;
   logic [LEN_WORD-1:0]  len_q, len_d;
   logic [LEN_WORD-1:0]  word_cnt_q, word_cnt_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 mode_q, mode_d;
   logic                 order_q, order_d;
   logic [LEN_WORD-1:0]  pc_q, pc_d;
   logic [LEN_WORD-1:0]  data_q, data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 load_done_q, load_done_d;

   logic                 accepting;
   logic                 byte_last;
   logic                 word_last;
   logic [LEN_WORD-1:0]  rx_word;

   assign accepting = (state_q == S_LEN) || (state_q == S_DATA);
   assign byte_last = accepting && rx_valid && (byte_cnt_q == 2'd3);
   assign rx_word   = {shift_q[LEN_WORD-9:0], rx_data};
   assign word_last = (word_cnt_q + LEN_WORD'(1)) == len_q;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_LEN;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LEN:   if (byte_last) state_d = (rx_word != '0) ? S_DATA : S_DRAIN;
         S_DATA:  if (byte_last && word_last) state_d = S_DRAIN;
         S_DRAIN: if (drain_q == DRAIN_W'(1)) state_d = S_ACK;
         S_ACK:   if (tx_valid_q && tx_ready) state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_LEN;
      endcase
   end

   // Datapath and output next values; order is a single-cycle pulse
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      len_d       = len_q;
      word_cnt_d  = word_cnt_q;
      drain_d     = drain_q;
      mode_d      = mode_q;
      order_d     = 1'b0;
      pc_d        = pc_q;
      data_d      = data_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = ACK_BYTE;
      load_done_d = load_done_q;

      if (accepting && rx_valid) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         shift_d    = rx_word;
      end

      case (state_q)
         S_LEN: begin
            if (byte_last) begin
               len_d = rx_word;
               if (rx_word == '0) drain_d = DRAIN_W'(DRAIN_CYCLES);
            end
         end
         S_DATA: begin
            if (byte_last) begin
               order_d    = 1'b1;
               data_d     = rx_word;
               pc_d       = START_PC + (word_cnt_q << 2);
               word_cnt_d = word_cnt_q + LEN_WORD'(1);
               if (word_last) drain_d = DRAIN_W'(DRAIN_CYCLES);
            end
         end
         S_DRAIN: begin
            drain_d = drain_q - DRAIN_W'(1);
            if (drain_q == DRAIN_W'(1)) tx_valid_d = 1'b1;
         end
         S_ACK: begin
            if (tx_valid_q && tx_ready) begin
               tx_valid_d  = 1'b0;
               mode_d      = 1'b0;
               load_done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         len_q       <= '0;
         word_cnt_q  <= '0;
         drain_q     <= '0;
         mode_q      <= 1'b1;
         order_q     <= 1'b0;
         pc_q        <= START_PC;
         data_q      <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= ACK_BYTE;
         load_done_q <= 1'b0;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         len_q       <= len_d;
         word_cnt_q  <= word_cnt_d;
         drain_q     <= drain_d;
         mode_q      <= mode_d;
         order_q     <= order_d;
         pc_q        <= pc_d;
         data_q      <= data_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         load_done_q <= load_done_d;
      end
   end

   assign prold_info = {mode_q, order_q, pc_q, data_q};
   assign tx_valid   = tx_valid_q;
   assign tx_data    = tx_data_q;
   assign load_done  = load_done_q;

endmodule

// File: tb/tb_prold_loader.sv
// Bench for prold_loader: two instances (different START_PC / DRAIN_CYCLES) share
// one byte stream and are checked every cycle against a stream-level model.
module tb_prold_loader;

   logic        clk;
   logic        rstn;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready;
   logic        txv   [2];
   logic [7:0]  txd   [2];
   logic [65:0] info  [2];
   logic        ldone [2];

   prold_loader #(.START_PC(32'h0), .DRAIN_CYCLES(4)) dut0 (
      .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(txv[0]), .tx_ready(tx_ready), .tx_data(txd[0]),
      .prold_info(info[0]), .load_done(ldone[0]));

   prold_loader #(.START_PC(32'h100), .DRAIN_CYCLES(7)) dut1 (
      .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(txv[1]), .tx_ready(tx_ready), .tx_data(txd[1]),
      .prold_info(info[1]), .load_done(ldone[1]));

   always #5 clk = ~clk;

   int          checks;
   int          errors;
   int          cyc;
   logic [31:0] spc [2];
   int          dr  [2];

   // Stream-level reference model
   int          idx;
   logic [31:0] m_n;
   logic [31:0] m_w;
   int unsigned m_k;
   logic        done;
   logic        done_pending;
   int          done_cyc;
   logic        exp_order;
   logic [31:0] exp_word;
   int unsigned exp_k;
   logic        released [2];
   logic        exp_txv  [2];
   logic [31:0] m_pc     [2];
   logic [31:0] m_data   [2];

   function automatic string tg(string s, int d);
      return $sformatf("%s[dut%0d]", s, d);
   endfunction

   task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      logic hs [2];
      for (int d = 0; d < 2; d++) hs[d] = rstn && exp_txv[d] && tx_ready;
      @(negedge clk);
      cyc++;
      if (done_pending) begin
         done = 1'b1;
         done_cyc = cyc;
         done_pending = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
         if (!rstn) begin
            chk(tg("rst_mode", d),  32'(info[d][65]), 32'h1);
            chk(tg("rst_order", d), 32'(info[d][64]), 32'h0);
            chk(tg("rst_pc", d),    info[d][63:32],   spc[d]);
            chk(tg("rst_data", d),  info[d][31:0],    32'h0);
            chk(tg("rst_txv", d),   32'(txv[d]),      32'h0);
            chk(tg("rst_txd", d),   32'(txd[d]),      32'hAA);
            chk(tg("rst_done", d),  32'(ldone[d]),    32'h0);
         end else begin
            if (hs[d]) released[d] = 1'b1;
            if (exp_order) begin
               m_pc[d]   = spc[d] + 32'(exp_k * 4);
               m_data[d] = exp_word;
            end
            exp_txv[d] = done && !released[d] && ((cyc - done_cyc) >= dr[d]);
            chk(tg("order", d),     32'(info[d][64]), 32'(exp_order));
            chk(tg("pc", d),        info[d][63:32],   m_pc[d]);
            chk(tg("data", d),      info[d][31:0],    m_data[d]);
            chk(tg("mode", d),      32'(info[d][65]), 32'(!released[d]));
            chk(tg("load_done", d), 32'(ldone[d]),    32'(released[d]));
            chk(tg("tx_valid", d),  32'(txv[d]),      32'(exp_txv[d]));
            chk(tg("tx_data", d),   32'(txd[d]),      32'hAA);
         end
      end
      exp_order = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      if (!done && !done_pending) begin
         if (idx < 4) begin
            m_n = {m_n[23:0], b};
            idx++;
            if (idx == 4 && m_n == 32'h0) done_pending = 1'b1;
         end else begin
            m_w = {m_w[23:0], b};
            idx++;
            if ((idx - 4) % 4 == 0) begin
               exp_order = 1'b1;
               exp_word  = m_w;
               exp_k     = m_k;
               m_k++;
               if (m_k == m_n) done_pending = 1'b1;
            end
         end
      end
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(logic [31:0] w, int gap);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[8*i +: 8]);
         idle(gap);
      end
   endtask

   task automatic wait_release();
      for (int i = 0; i < 200 && !(released[0] && released[1]); i++) tick();
      chk("release_timeout", 32'(released[0] && released[1]), 32'h1);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rstn = 1'b0;
      idx = 0; m_n = '0; m_w = '0; m_k = 0;
      done = 1'b0; done_pending = 1'b0; done_cyc = 0;
      exp_order = 1'b0; exp_word = '0; exp_k = 0;
      for (int d = 0; d < 2; d++) begin
         released[d] = 1'b0;
         exp_txv[d]  = 1'b0;
         m_pc[d]     = spc[d];
         m_data[d]   = '0;
      end
      idle(2);
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      clk = 1'b0; rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
      checks = 0; errors = 0; cyc = 0;
      spc[0] = 32'h0;   dr[0] = 4;
      spc[1] = 32'h100; dr[1] = 7;

      // Two words with 3-cycle gaps
      do_reset();
      send_word(32'h2, 3);
      send_word(32'h13001000, 3);
      send_word(32'h6F000000, 3);
      wait_release();
      idle(3);

      // Empty program
      do_reset();
      send_word(32'h0, 1);
      wait_release();
      idle(2);

      // Back-to-back bytes, three random words
      do_reset();
      send_word(32'h3, 0);
      for (int i = 0; i < 3; i++) send_word($urandom, 0);
      wait_release();

      // Ack held off by tx_ready low
      do_reset();
      tx_ready = 1'b0;
      send_word(32'h1, 0);
      send_word($urandom, 0);
      idle(30);
      chk("held_not_released", 32'(released[0] || released[1]), 32'h0);
      tx_ready = 1'b1;
      wait_release();

      // Reset mid-load, then a fresh single-word load
      do_reset();
      send_word(32'h2, 1);
      send_byte(8'h11);
      send_byte(8'h22);
      rstn = 1'b0;
      do_reset();
      send_word(32'h1, 2);
      send_word(32'hDEADBEEF, 2);
      wait_release();

      // Bytes after release are ignored
      for (int i = 0; i < 10; i++) send_byte(8'($urandom));
      idle(2);

      // Random loads with random gaps
      for (int t = 0; t < 3; t++) begin
         int n;
         int gap;
         n   = $urandom_range(1, 4);
         gap = $urandom_range(0, 3);
         do_reset();
         send_word(32'(n), gap);
         for (int i = 0; i < n; i++) send_word($urandom, gap);
         wait_release();
         idle(2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
